dmem_stream_loader: RTL

- Writer-side counterpart to the data-memory read path: accepts a byte stream with a valid/ready handshake and writes it into dmem through its write port (daddr/dwdata/dwrite/dsize).
- Packs bytes big-endian into words and writes whole words; a trailing partial word is flushed as single-byte writes.
- Sits between a host/debug byte source and dmem, preloading data without $readmemh.

---
 rtl/dmem_stream_loader_if.sv | 32 +++
 rtl/dmem_stream_loader.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/dmem_stream_loader_if.sv
// Bundle of the host-side byte stream, load control/status and dmem write port
// used by dmem_stream_loader.
interface dmem_stream_loader_if #(
    parameter int COUNT_W = 16
);
    logic               start;
    logic [31:0]        base_addr;
    logic [COUNT_W-1:0] byte_count;
    logic               in_valid;
    logic [7:0]         in_data;
    logic               in_ready;
    logic [31:0]        daddr;
    logic [31:0]        dwdata;
    logic               dwrite;
    logic [1:0]         dsize;
    logic               busy;
    logic               done;
    logic               err;
    logic [COUNT_W-1:0] bytes_loaded;

    // Host / byte-source side.
    modport master (
        output start, base_addr, byte_count, in_valid, in_data,
        input  in_ready, daddr, dwdata, dwrite, dsize, busy, done, err, bytes_loaded
    );

    // Loader side.
    modport slave (
        input  start, base_addr, byte_count, in_valid, in_data,
        output in_ready, daddr, dwdata, dwrite, dsize, busy, done, err, bytes_loaded
    );
endinterface

// File: rtl/dmem_stream_loader.sv
// Packs an incoming byte stream big-endian into words and writes them into dmem;
// a trailing partial word is flushed as individual byte writes.
module dmem_stream_loader #(
    parameter int COUNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    dmem_stream_loader_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_FLUSH,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        word_q, word_d;
    logic [COUNT_W-1:0] remaining_q, remaining_d;
    logic [COUNT_W-1:0] loaded_q, loaded_d;
    logic [1:0]         idx_q, idx_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic [31:0]        hold_addr_q, hold_addr_d;
    logic [31:0]        hold_data_q, hold_data_d;
    logic [1:0]         hold_size_q, hold_size_d;

    logic               in_ready_c;
    logic               dwrite_c;
    logic [31:0]        wr_addr_c;
    logic [31:0]        wr_data_c;
    logic [1:0]         wr_size_c;

    // NOTE: every variable gets a default before the case so no path can leave
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        word_d      = word_q;
        remaining_d = remaining_q;
        loaded_d    = loaded_q;
        idx_d       = idx_q;
        err_d       = 1'b0;
        done_d      = 1'b0;
        in_ready_c  = 1'b0;
        dwrite_c    = 1'b0;
        wr_addr_c   = hold_addr_q;
        wr_data_c   = hold_data_q;
        wr_size_c   = hold_size_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.base_addr[1:0] != 2'b00) begin
                        err_d = 1'b1;
                    end else if (bus.byte_count == '0) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d      = bus.base_addr;
                        remaining_d = bus.byte_count;
                        loaded_d    = '0;
                        idx_d       = 2'd0;
                        state_d     = S_COLLECT;
                    end
                end
            end

            S_COLLECT: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    unique case (idx_q)
                        2'd0: word_d[31:24] = bus.in_data;
                        2'd1: word_d[23:16] = bus.in_data;
                        2'd2: word_d[15:8]  = bus.in_data;
                        2'd3: word_d[7:0]   = bus.in_data;
                    endcase
                    idx_d       = idx_q + 2'd1;
                    remaining_d = remaining_q - COUNT_W'(1);
                    if (idx_q == 2'd3) begin
                        state_d = S_WRITE;
                    end else if (remaining_q == COUNT_W'(1)) begin
                        state_d = S_FLUSH;
                    end
                end
            end

            S_WRITE: begin
                dwrite_c  = 1'b1;
                wr_addr_c = addr_q;
                wr_data_c = word_q;
                wr_size_c = 2'b10;
                addr_d    = addr_q + 32'd4;
                loaded_d  = loaded_q + COUNT_W'(4);
                idx_d     = 2'd0;
                state_d   = (remaining_q == '0) ? S_DONE : S_COLLECT;
            end

            // Buffered bytes sit left-justified in word_q; shift one out per cycle.
            S_FLUSH: begin
                dwrite_c  = 1'b1;
                wr_addr_c = addr_q;
                wr_data_c = {24'h0, word_q[31:24]};
                wr_size_c = 2'b00;
                addr_d    = addr_q + 32'd1;
                loaded_d  = loaded_q + COUNT_W'(1);
                word_d    = {word_q[23:0], 8'h00};
                idx_d     = idx_q - 2'd1;
                if (idx_q == 2'd1) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        hold_addr_d = dwrite_c ? wr_addr_c : hold_addr_q;
        hold_data_d = dwrite_c ? wr_data_c : hold_data_q;
        hold_size_d = dwrite_c ? wr_size_c : hold_size_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            word_q      <= '0;
            remaining_q <= '0;
            loaded_q    <= '0;
            idx_q       <= 2'd0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            hold_size_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            word_q      <= word_d;
            remaining_q <= remaining_d;
            loaded_q    <= loaded_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            done_q      <= done_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            hold_size_q <= hold_size_d;
        end
    end

    assign bus.in_ready     = in_ready_c;
    assign bus.dwrite       = dwrite_c;
    assign bus.daddr        = wr_addr_c;
    assign bus.dwdata       = wr_data_c;
    assign bus.dsize        = wr_size_c;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.bytes_loaded = loaded_q;
endmodule
